// File: rtl/kt_cmd_pkg.sv
// Shared opcodes, FSM states and response codes for the command processor.
package kt_cmd_pkg;

  typedef enum logic [3:0] {
    OP_CAL  = 4'h2,
    OP_MOVE = 4'h4,
    OP_FAN  = 4'h5,
    OP_TOUR = 4'h6,
    OP_STOP = 4'h7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAL,
    ST_TOUR,
    ST_SDLY,
    ST_SETTLE,
    ST_RAMPUP,
    ST_RAMPDN
  } state_t;

  typedef logic [7:0] resp_t;

  localparam resp_t RESP_ACK = 8'hA5;
  localparam resp_t RESP_NAK = 8'hEE;

endpackage

// File: rtl/cmd_proc_param_if.sv
// Command/response handshake between UART_wrapper (master) and the processor (slave).
interface cmd_proc_param_if;
  import kt_cmd_pkg::*;

  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  resp_t       resp;

  modport master (output cmd, cmd_rdy, input clr_cmd_rdy, send_resp, resp);
  modport slave  (input cmd, cmd_rdy, output clr_cmd_rdy, send_resp, resp);

endinterface

// File: rtl/cmd_frwrd_ramp.sv
// Forward-speed register: clear, saturating ramp up, floor-clamped ramp down.
// Ramp steps only land on heading_rdy so speed tracks the gyro update rate.
module cmd_frwrd_ramp #(
  parameter int FRWRD_W  = 10,
  parameter int INC_STEP = 'h20,
  parameter int DEC_STEP = 'h40,
  parameter int MAX_SPD  = 'h300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic               dec,
  input  logic               en,
  output logic [FRWRD_W-1:0] frwrd
);

  localparam logic [FRWRD_W:0]   INC_V = (FRWRD_W+1)'(INC_STEP);
  localparam logic [FRWRD_W:0]   MAX_V = (FRWRD_W+1)'(MAX_SPD);
  localparam logic [FRWRD_W-1:0] DEC_V = FRWRD_W'(DEC_STEP);

  logic [FRWRD_W-1:0] frwrd_q, frwrd_d;
  logic [FRWRD_W:0]   sum;

  // One extra bit on the sum so the ceiling compare sees overflow instead of a wrap.
  assign sum = {1'b0, frwrd_q} + INC_V;

  // Next speed: clear wins, then ramp up/down when a heading update arrives.
  always_comb begin
    frwrd_d = frwrd_q;
    if (clr) begin
      frwrd_d = '0;
    end else if (en && inc) begin
      frwrd_d = (sum > MAX_V) ? MAX_V[FRWRD_W-1:0] : sum[FRWRD_W-1:0];
    end else if (en && dec) begin
      frwrd_d = (frwrd_q > DEC_V) ? frwrd_q - DEC_V : '0;
    end
  end

  // Speed register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frwrd_q <= '0;
    else     frwrd_q <= frwrd_d;
  end

  assign frwrd = frwrd_q;

endmodule

// File: rtl/cmd_proc_param.sv
// Knight's Tour command processor: decodes UART commands, sequences moves,
// drives the PID heading error and ramped forward speed.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | waiting for a command; only state that accepts non-STOP cmds
//  CAL       | calibration running, waiting for cal_done
//  TOUR      | one cycle to pulse tour_go
//  SDLY      | one cycle so error reflects the newly latched desired_hdg
//  SETTLE    | turning in place until |error| < SETTLE_THR
//  RAMPUP    | accelerating/cruising until the square count is reached
//  RAMPDN    | decelerating to zero, then respond
module cmd_proc_param import kt_cmd_pkg::*; #(
  parameter int HEAD_W       = 12,
  parameter int FRWRD_W      = 10,
  parameter int INC_STEP     = 'h20,
  parameter int DEC_STEP     = 'h40,
  parameter int MAX_SPD      = 'h300,
  parameter int NUDGE        = 'h1FF,
  parameter int SETTLE_THR   = 'h02C,
  parameter int LINES_PER_SQ = 2,
  parameter int TIMEOUT_CYC  = 2**24
) (
  input  logic               clk,
  input  logic               rst,
  cmd_proc_param_if.slave    bus,
  output logic               strt_cal,
  input  logic               cal_done,
  output logic               tour_go,
  input  logic [HEAD_W-1:0]  heading,
  input  logic               heading_rdy,
  output logic               moving,
  input  logic               lftIR,
  input  logic               cntrIR,
  input  logic               rghtIR,
  output logic               fanfare_go,
  output logic [FRWRD_W-1:0] frwrd,
  output logic [HEAD_W-1:0]  error
);

  localparam int LC_W  = 8;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [HEAD_W-1:0]        NUDGE_V = HEAD_W'(NUDGE);
  localparam logic signed [HEAD_W-1:0] THR_V   = HEAD_W'(SETTLE_THR);
  localparam logic [TMO_W-1:0]         TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [HEAD_W-1:0] desired_hdg_q, desired_hdg_d;
  logic [2:0]        squares_q, squares_d;
  logic              fan_q, fan_d;
  logic              nak_q, nak_d;
  logic [LC_W-1:0]   line_cntr_q, line_cntr_d;
  logic              cntr_ir_q;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  resp_t             resp_q, resp_d;

  opcode_t           opcode;
  logic [7:0]        cmd_hdg;
  logic [HEAD_W-1:0] new_hdg, err_nudge;
  logic signed [HEAD_W-1:0] err_s;
  logic              settled, move_done, timed_out, is_stop, accept, ramp_inc, ramp_dec;
  logic              unused_cmd_bit;

  assign opcode         = opcode_t'(bus.cmd[15:12]);
  assign cmd_hdg        = bus.cmd[11:4];
  assign unused_cmd_bit = bus.cmd[3];
  assign is_stop        = bus.cmd_rdy && (opcode == OP_STOP);

  // A zero heading field means "north" exactly; otherwise fill the low bits with ones.
  assign new_hdg = (cmd_hdg == 8'h00) ? '0 : {cmd_hdg, {(HEAD_W-8){1'b1}}};

  // IR guard sensors push the error away from the side that sees a wall.
  always_comb begin
    err_nudge = '0;
    if (lftIR)       err_nudge = NUDGE_V;
    else if (rghtIR) err_nudge = -NUDGE_V;
  end

  assign error     = heading - desired_hdg_q + err_nudge;
  assign err_s     = $signed(error);
  assign settled   = (err_s < THR_V) && (err_s > -THR_V);
  assign move_done = line_cntr_q >= LC_W'(32'(squares_q) * LINES_PER_SQ);
  assign timed_out = (tmo_cnt_q == TMO_LAST);
  assign moving    = (state_q == ST_SETTLE) || (state_q == ST_RAMPUP) || (state_q == ST_RAMPDN);

  // Line counter: cntrIR rising edges, saturating, cleared when a move is accepted.
  always_comb begin
    line_cntr_d = line_cntr_q;
    if (accept)                                   line_cntr_d = '0;
    else if (cntrIR && !cntr_ir_q && ~&line_cntr_q) line_cntr_d = line_cntr_q + 1'b1;
  end

  // Next-state and output decode; STOP beats move_done beats timeout.
  always_comb begin
    state_d         = state_q;
    desired_hdg_d   = desired_hdg_q;
    squares_d       = squares_q;
    fan_d           = fan_q;
    nak_d           = nak_q;
    tmo_cnt_d       = tmo_cnt_q;
    resp_d          = resp_q;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp   = 1'b0;
    strt_cal        = 1'b0;
    tour_go         = 1'b0;
    fanfare_go      = 1'b0;
    accept          = 1'b0;
    ramp_inc        = 1'b0;
    ramp_dec        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_rdy) begin
          bus.clr_cmd_rdy = 1'b1;
          case (opcode)
            OP_CAL: begin
              strt_cal = 1'b1;
              state_d  = ST_CAL;
            end
            OP_TOUR: state_d = ST_TOUR;
            OP_MOVE, OP_FAN: begin
              accept        = 1'b1;
              tmo_cnt_d     = '0;
              desired_hdg_d = new_hdg;
              squares_d     = bus.cmd[2:0];
              fan_d         = (opcode == OP_FAN);
              nak_d         = 1'b0;
              state_d       = ST_SDLY;
            end
            OP_STOP: begin
              bus.send_resp = 1'b1;
              resp_d        = RESP_ACK;
            end
            default: begin
              bus.send_resp = 1'b1;
              resp_d        = RESP_NAK;
            end
          endcase
        end
      end
      ST_CAL: begin
        if (cal_done) begin
          bus.send_resp = 1'b1;
          resp_d        = RESP_ACK;
          state_d       = ST_IDLE;
        end
      end
      ST_TOUR: begin
        tour_go = 1'b1;
        state_d = ST_IDLE;
      end
      ST_SDLY, ST_SETTLE, ST_RAMPUP: begin
        if (is_stop) begin
          bus.clr_cmd_rdy = 1'b1;
          fan_d           = 1'b0;
          nak_d           = 1'b0;
          state_d         = ST_RAMPDN;
        end else if (state_q == ST_SDLY) begin
          state_d = ST_SETTLE;
        end else if ((state_q == ST_RAMPUP) && move_done) begin
          state_d = ST_RAMPDN;
        end else if (timed_out) begin
          nak_d   = 1'b1;
          fan_d   = 1'b0;
          state_d = ST_RAMPDN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          ramp_inc  = (state_q == ST_RAMPUP);
          if ((state_q == ST_SETTLE) && settled) state_d = ST_RAMPUP;
        end
      end
      ST_RAMPDN: begin
        bus.clr_cmd_rdy = is_stop;
        if (frwrd == '0) begin
          bus.send_resp = 1'b1;
          resp_d        = nak_q ? RESP_NAK : RESP_ACK;
          fanfare_go    = fan_q;
          state_d       = ST_IDLE;
        end else begin
          ramp_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.resp = resp_d;

  // Control and move-context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      desired_hdg_q <= '0;
      squares_q     <= '0;
      fan_q         <= 1'b0;
      nak_q         <= 1'b0;
      line_cntr_q   <= '0;
      cntr_ir_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      resp_q        <= RESP_ACK;
    end else begin
      state_q       <= state_d;
      desired_hdg_q <= desired_hdg_d;
      squares_q     <= squares_d;
      fan_q         <= fan_d;
      nak_q         <= nak_d;
      line_cntr_q   <= line_cntr_d;
      cntr_ir_q     <= cntrIR;
      tmo_cnt_q     <= tmo_cnt_d;
      resp_q        <= resp_d;
    end
  end

  cmd_frwrd_ramp #(
    .FRWRD_W (FRWRD_W),
    .INC_STEP(INC_STEP),
    .DEC_STEP(DEC_STEP),
    .MAX_SPD (MAX_SPD)
  ) u_ramp (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (ramp_inc),
    .dec  (ramp_dec),
    .en   (heading_rdy),
    .frwrd(frwrd)
  );

endmodule

// File: tb/tb_cmd_proc_param.sv
// Directed bench for cmd_proc_param with a response scoreboard.
module tb_cmd_proc_param;
  import kt_cmd_pkg::*;

  typedef struct packed { logic [7:0] resp; logic fan; } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cal_done = 1'b0, heading_rdy = 1'b0;
  logic        lftIR = 1'b0, cntrIR = 1'b0, rghtIR = 1'b0;
  logic [11:0] heading = '0;
  logic        strt_cal, tour_go, moving, fanfare_go;
  logic [9:0]  frwrd;
  logic [11:0] error;

  int   vectors = 0, miscompares = 0;
  int   cyc = 0, acc_cyc = 0, resp_cyc = 0;
  int   cal_cnt = 0, tour_cnt = 0, fan_cnt = 0;
  exp_t sb[$];

  cmd_proc_param_if bus_if ();

  cmd_proc_param #(.TIMEOUT_CYC(1000)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .strt_cal(strt_cal), .cal_done(cal_done),
    .tour_go(tour_go), .heading(heading), .heading_rdy(heading_rdy), .moving(moving),
    .lftIR(lftIR), .cntrIR(cntrIR), .rghtIR(rghtIR), .fanfare_go(fanfare_go),
    .frwrd(frwrd), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Response monitor: every send_resp must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (strt_cal)   cal_cnt++;
      if (tour_go)    tour_cnt++;
      if (fanfare_go) begin
        fan_cnt++;
        check("fan_with_resp", bus_if.send_resp, 1);
      end
      if (bus_if.send_resp) begin
        resp_cyc = cyc;
        check("resp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("resp_byte", bus_if.resp, e.resp);
          check("resp_fanfare", fanfare_go, e.fan);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] c);
    bus_if.cmd = c;
    bus_if.cmd_rdy = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    check($sformatf("clr_%h", c), bus_if.clr_cmd_rdy, 1);
    tick(1);
    bus_if.cmd_rdy = 1'b0;
  endtask

  task automatic hrdy(input logic [9:0] exp, input string tag);
    heading_rdy = 1'b1;
    tick(1);
    heading_rdy = 1'b0;
    tick(1);
    check(tag, frwrd, exp);
  endtask

  task automatic line_pulse();
    cntrIR = 1'b1;
    tick(2);
    cntrIR = 1'b0;
    tick(2);
  endtask

  task automatic wait_resp(int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    logic [9:0] f;
    int d, n;
    bus_if.cmd = '0;
    bus_if.cmd_rdy = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_frwrd", frwrd, 0);
    check("rst_moving", moving, 0);
    check("rst_resp", bus_if.resp, RESP_ACK);
    check("rst_send", bus_if.send_resp, 0);
    check("rst_error", error, 0);
    tick(1);

    lftIR = 1'b1;              #1 check("err_lft", error, 12'h1FF);
    lftIR = 1'b0; rghtIR = 1'b1; #1 check("err_rght", error, 12'hE01);
    rghtIR = 1'b0; heading = 12'h123; #1 check("err_hdg", error, 12'h123);
    heading = '0;
    tick(1);

    // calibrate
    sb.push_back('{RESP_ACK, 1'b0});
    send_cmd(16'h2000);
    check("cal_strt", cal_cnt, 1);
    tick(50);
    check("cal_wait", sb.size(), 1);
    cal_done = 1'b1;
    tick(1);
    cal_done = 1'b0;
    wait_resp(5, "cal_resp");

    // illegal opcode, idle stop, tour
    sb.push_back('{RESP_NAK, 1'b0});
    send_cmd(16'hF000);
    wait_resp(5, "nak_resp");
    sb.push_back('{RESP_ACK, 1'b0});
    send_cmd(16'h7000);
    wait_resp(5, "stop_idle_resp");
    send_cmd(16'h6000);
    tick(3);
    check("tour_go", tour_cnt, 1);
    check("tour_no_resp", sb.size(), 0);

    // latched desired heading, stopped while settling
    send_cmd(16'h4A51);
    @(negedge clk);
    check("err_desired", error, 12'h5A1);
    tick(3);
    check("settle_moving", moving, 1);
    sb.push_back('{RESP_ACK, 1'b0});
    send_cmd(16'h7000);
    wait_resp(5, "settle_stop_resp");

    // full move: ramp to ceiling, two lines, ramp to zero
    send_cmd(16'h4001);
    tick(4);
    f = '0;
    for (int k = 0; k < 26; k++) begin
      f = (f + 10'h20 > 10'h300) ? 10'h300 : f + 10'h20;
      hrdy(f, "rampup");
    end
    sb.push_back('{RESP_ACK, 1'b0});
    line_pulse();
    line_pulse();
    tick(2);
    for (int k = 0; k < 12; k++) begin
      f = (f > 10'h40) ? f - 10'h40 : 10'h0;
      hrdy(f, "rampdn");
    end
    wait_resp(5, "move_resp");

    // fanfare move, two squares
    n = fan_cnt;
    sb.push_back('{RESP_ACK, 1'b1});
    send_cmd(16'h5002);
    tick(3);
    repeat (3) line_pulse();
    check("fan_early", sb.size(), 1);
    line_pulse();
    wait_resp(10, "fan_resp");
    check("fan_cnt", fan_cnt - n, 1);

    // stop mid-ramp on a fanfare move
    n = fan_cnt;
    send_cmd(16'h5007);
    tick(3);
    f = '0;
    for (int k = 0; k < 8; k++) begin
      f = f + 10'h20;
      hrdy(f, "stop_rampup");
    end
    sb.push_back('{RESP_ACK, 1'b0});
    send_cmd(16'h7000);
    tick(1);
    for (int k = 0; k < 4; k++) begin
      f = f - 10'h40;
      hrdy(f, "stop_rampdn");
    end
    wait_resp(5, "stop_resp");
    check("stop_no_fan", fan_cnt - n, 0);

    // settle threshold is strict
    heading = 12'h02C;
    send_cmd(16'h4003);
    tick(5);
    hrdy(10'h0, "thr_hold");
    heading = 12'h02B;
    tick(3);
    hrdy(10'h20, "thr_release");
    sb.push_back('{RESP_ACK, 1'b0});
    send_cmd(16'h7000);
    hrdy(10'h0, "thr_rampdn");
    wait_resp(5, "thr_resp");
    heading = '0;

    // zero squares
    sb.push_back('{RESP_ACK, 1'b0});
    send_cmd(16'h4000);
    wait_resp(10, "sq0_resp");

    // timeout with no lines
    sb.push_back('{RESP_NAK, 1'b0});
    send_cmd(16'h4001);
    n = acc_cyc;
    wait_resp(1100, "tmo_resp");
    d = resp_cyc - n;
    check("tmo_cycles", (d >= 1000 && d <= 1004), 1);

    // reset mid-ramp
    send_cmd(16'h4001);
    tick(3);
    for (int k = 1; k <= 3; k++) hrdy(10'(k * 'h20), "rst_ramp");
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frwrd", frwrd, 0);
    check("rst_mid_moving", moving, 0);
    tick(1);
    rst = 1'b0;
    tick(2);
    sb.push_back('{RESP_ACK, 1'b0});
    send_cmd(16'h7000);
    wait_resp(5, "post_rst_resp");

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
